// File: rtl/inport_pkg.sv
// Shared types and status-word layout for the input-port handshake controller.
package inport_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2,
        ERR     = 2'd3
    } state_t;

    localparam int ST_READY   = 0;
    localparam int ST_ERROR   = 1;
    localparam int ST_CNT_LSB = 8;
endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input, clearable at reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/inport_ctrl.sv
// Four-phase device handshake for the input port register: capture strobe,
// ready/back-pressure, ack timeout, transfer count and status word.
module inport_ctrl
    import inport_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT        = 255,
    parameter int CNT_WIDTH      = 8,
    parameter int DATA_WIDTH_OUT = 32
) (
    input  logic                      Clock,
    input  logic                      Clear,
    input  logic                      DevReq,
    output logic                      DevAck,
    output logic                      Strobe,
    input  logic                      CpuRead,
    input  logic                      IntEn,
    input  logic                      StatusClr,
    output logic                      Ready,
    output logic                      IntReq,
    output logic [DATA_WIDTH_OUT-1:0] StatusOut
);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t               state, nxt;
    logic                 req_s;
    logic [15:0]          timer;
    logic [CNT_WIDTH-1:0] count;
    logic                 ready, error, dev_ack, strobe, int_req;

    sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (Clock),
        .rst_n (Clear),
        .d     (DevReq),
        .q     (req_s)
    );

    // A stalled device (ready still set) waits in IDLE without an ack.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req_s && !ready) nxt = CAPTURE;
            CAPTURE: nxt = ACK;
            ACK:     if (!req_s) nxt = IDLE;
                     else if (timer == TMO_LAST) nxt = ERR;
            ERR:     if (!req_s) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state   <= IDLE;
            timer   <= '0;
            count   <= '0;
            ready   <= 1'b0;
            error   <= 1'b0;
            dev_ack <= 1'b0;
            strobe  <= 1'b0;
            int_req <= 1'b0;
        end else begin
            state   <= nxt;
            strobe  <= (nxt == CAPTURE);
            dev_ack <= (nxt == ACK);
            int_req <= ready & IntEn;
            // Capture has priority over a coincident CPU read.
            if (state == CAPTURE) begin
                ready <= 1'b1;
                count <= count + 1'b1;
                timer <= '0;
            end else begin
                if (CpuRead)       ready <= 1'b0;
                if (state == ACK)  timer <= timer + 16'd1;
            end
            if (state == ACK && nxt == ERR) error <= 1'b1;
            else if (StatusClr)             error <= 1'b0;
        end
    end

    always_comb begin
        StatusOut                           = '0;
        StatusOut[ST_READY]                 = ready;
        StatusOut[ST_ERROR]                 = error;
        StatusOut[ST_CNT_LSB +: CNT_WIDTH]  = count;
    end

    assign DevAck = dev_ack;
    assign Strobe = strobe;
    assign Ready  = ready;
    assign IntReq = int_req;
endmodule

// File: tb/tb_inport_ctrl.sv
// Directed bench for inport_ctrl with a strobe/count scoreboard.
module tb_inport_ctrl;
    logic        Clock = 1'b0;
    logic        Clear, DevReq, CpuRead, IntEn, StatusClr;
    logic        DevAck, Strobe, Ready, IntReq;
    logic [31:0] StatusOut;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    inport_ctrl #(
        .SYNC_STAGES(2), .TIMEOUT(4), .CNT_WIDTH(8), .DATA_WIDTH_OUT(32)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .DevReq    (DevReq),
        .DevAck    (DevAck),
        .Strobe    (Strobe),
        .CpuRead   (CpuRead),
        .IntEn     (IntEn),
        .StatusClr (StatusClr),
        .Ready     (Ready),
        .IntReq    (IntReq),
        .StatusOut (StatusOut)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_xfer(input int n);
        CpuRead = 1'b1; tick(); CpuRead = 1'b0;
        exp_q.push_back(8'(n));
        DevReq = 1'b1;
        for (int i = 0; i < 12 && !DevAck; i++) tick();
        chk("xfer_ack", {31'd0, DevAck}, 32'd1);
        DevReq = 1'b0;
        for (int i = 0; i < 12 && DevAck; i++) tick();
        chk("xfer_ack_drop", {31'd0, DevAck}, 32'd0);
    endtask

    // Scoreboard: every strobe must have been announced, and the count
    // one cycle later must match the announced transfer number.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge Clock);
            if (Strobe === 1'b1) begin
                chk("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    @(negedge Clock);
                    chk("strobe_cnt", {24'd0, StatusOut[15:8]}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        Clear = 1'b0; DevReq = 1'b0; CpuRead = 1'b0; IntEn = 1'b0; StatusClr = 1'b0;
        ticks(2);
        chk("rst_status", StatusOut, 32'h0);
        chk("rst_outs", {28'd0, DevAck, Strobe, Ready, IntReq}, 32'h0);
        Clear = 1'b1;
        tick();

        // single transfer
        exp_q.push_back(8'd1);
        DevReq = 1'b1;
        tick(); chk("st_strobe_c1", {31'd0, Strobe}, 32'd0);
        tick(); chk("st_strobe_c2", {31'd0, Strobe}, 32'd0);
        tick(); chk("st_strobe_c3", {31'd0, Strobe}, 32'd1);
        tick(); chk("st_strobe_c4", {31'd0, Strobe}, 32'd0);
        chk("st_ack", {31'd0, DevAck}, 32'd1);
        chk("st_ready", {31'd0, Ready}, 32'd1);
        chk("st_status", StatusOut, 32'h101);
        DevReq = 1'b0;
        ticks(2); chk("st_ack_hold", {31'd0, DevAck}, 32'd1);
        tick();   chk("st_ack_fall", {31'd0, DevAck}, 32'd0);

        // back-pressure: Ready still set, new request must stall
        DevReq = 1'b1;
        for (int c = 1; c < 20; c++) begin
            tick();
            chk("bp_no_strobe", {31'd0, Strobe}, 32'd0);
            chk("bp_no_ack", {31'd0, DevAck}, 32'd0);
        end
        exp_q.push_back(8'd2);
        CpuRead = 1'b1; tick(); CpuRead = 1'b0;
        chk("bp_ready_clr", {31'd0, Ready}, 32'd0);
        tick(); chk("bp_strobe", {31'd0, Strobe}, 32'd1);
        tick(); chk("bp_status", StatusOut, 32'h201);
        DevReq = 1'b0;
        ticks(3); chk("bp_ack_fall", {31'd0, DevAck}, 32'd0);

        // timeout with request held high
        CpuRead = 1'b1; tick(); CpuRead = 1'b0;
        exp_q.push_back(8'd3);
        DevReq = 1'b1;
        ticks(3); chk("to_strobe", {31'd0, Strobe}, 32'd1);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (DevAck) acks++;
        end
        chk("to_ack_cycles", 32'(acks), 32'd4);
        chk("to_status_err", StatusOut, 32'h303);
        StatusClr = 1'b1; tick(); StatusClr = 1'b0;
        chk("to_err_clr", StatusOut, 32'h301);
        DevReq = 1'b0;
        ticks(4); chk("to_ack_low", {31'd0, DevAck}, 32'd0);

        // read collides with capture; set wins
        CpuRead = 1'b1; tick(); CpuRead = 1'b0;
        exp_q.push_back(8'd4);
        DevReq = 1'b1;
        ticks(3); chk("col_strobe", {31'd0, Strobe}, 32'd1);
        CpuRead = 1'b1; DevReq = 1'b0;
        tick(); CpuRead = 1'b0;
        chk("col_ready", {31'd0, Ready}, 32'd1);
        chk("col_intreq_off", {31'd0, IntReq}, 32'd0);
        IntEn = 1'b1;
        tick(); chk("col_intreq_on", {31'd0, IntReq}, 32'd1);
        IntEn = 1'b0;
        ticks(4); chk("col_ack_low", {31'd0, DevAck}, 32'd0);

        // counter wrap: total of 256 transfers
        for (int n = 5; n <= 256; n++) do_xfer(n);
        tick();
        chk("wrap_status", StatusOut, 32'h001);

        // asynchronous reset while in ACK
        CpuRead = 1'b1; tick(); CpuRead = 1'b0;
        exp_q.push_back(8'd1);
        DevReq = 1'b1;
        ticks(5); chk("ar_in_ack", {31'd0, DevAck}, 32'd1);
        #3 Clear = 1'b0;
        #1;
        chk("ar_outs", {29'd0, DevAck, Strobe, Ready}, 32'h0);
        chk("ar_status", StatusOut, 32'h0);
        DevReq = 1'b0;
        ticks(2);
        Clear = 1'b1;
        tick();
        exp_q.push_back(8'd1);
        DevReq = 1'b1;
        ticks(3); chk("ar_post_strobe", {31'd0, Strobe}, 32'd1);
        tick();   chk("ar_post_status", StatusOut, 32'h101);
        DevReq = 1'b0;
        ticks(3); chk("ar_post_ack_fall", {31'd0, DevAck}, 32'd0);
        ticks(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inport_ctrl.md
# inport_ctrl

Handshake controller for the MiniSRC input port register. It synchronises a four-phase request from an external device and pulses `Strobe` so the port register captures the device data. It then holds the data as "ready" until the CPU's `in` instruction consumes it, and back-pressures the device in the meantime. It sits between the device pins and the port register, and exports a bus-readable status word and an interrupt request.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `DevReq` synchroniser (≥2).
- `TIMEOUT`, 255: maximum cycles in ACK waiting for `DevReq` to drop (1..2^16-1).
- `CNT_WIDTH`, 8: width of the transfer counter (≤16).
- `DATA_WIDTH_OUT`, 32: status word width.

- `Clock` in 1: sole clock, rising edge.
- `Clear` in 1: asynchronous, active-low reset.
- `DevReq` in 1: device request, asynchronous to `Clock`, four-phase.
- `DevAck` out 1: acknowledge to device.
- `Strobe` out 1: one-cycle load pulse to the input port register.
- `CpuRead` in 1: one-cycle pulse; the CPU has read the port register onto the bus.
- `IntEn` in 1: interrupt enable.
- `StatusClr` in 1: one-cycle pulse; clears the sticky Error bit.
- `Ready` out 1: port register holds unread data.
- `IntReq` out 1: equal to `Ready & IntEn`, registered.
- `StatusOut` out `DATA_WIDTH_OUT`: status word. Bit 0 is `Ready`, bit 1 is `Error`, bits [8+CNT_WIDTH-1:8] are the transfer count, and all other bits are 0.

## Operation
- **Reset:** asserting `Clear` low immediately sets the FSM to IDLE and clears the synchroniser, timer, transfer count, `Ready`, `Error`, `DevAck`, `Strobe` and `IntReq`. `StatusOut` reads 0.
- **Synchroniser:** `req_s` is `DevReq` delayed by `SYNC_STAGES` flip-flops. The FSM uses only `req_s`.
- **FSM states:**
  - IDLE: `DevAck`=0. If `req_s`=1 and `Ready`=0, go to CAPTURE. If `Ready`=1, stay in IDLE; the device is stalled with no ack.
  - CAPTURE: `Strobe`=1 for exactly this cycle. On exit `Ready` is set, the count increments (wrapping modulo 2^CNT_WIDTH), and the timer clears. Go to ACK.
  - ACK: `DevAck`=1 and the timer increments each cycle. If `req_s`=0, go to IDLE. Otherwise, if the timer equals `TIMEOUT`-1, go to ERR and set `Error`.
  - ERR: `DevAck`=0. Go to IDLE when `req_s`=0. Data already captured stays valid and `Ready` is unaffected.
- **Ready:** cleared by `CpuRead` while `Ready`=1. `CpuRead` while `Ready`=0 is ignored. If set and clear occur in the same cycle, set wins.
- **Error:** sticky; cleared only by `StatusClr` or reset. If `StatusClr` coincides with a timeout-set, set wins.
- **ACK exit rule:** `DevReq` re-asserting while in ACK does not start a new transfer. A new transfer needs a return to IDLE first, so at most one capture occurs per request.
- **Reset mid-transfer:** `DevAck` drops immediately and no partial `Strobe` is issued.

## Timing
- The timeline below is for `DevReq` rising before edge E0, with `Ready`=0:
  - `req_s` is high after edge E0+`SYNC_STAGES`-1.
  - CAPTURE (`Strobe` high) is entered at edge E0+`SYNC_STAGES`.
  - The port register loads at edge E0+`SYNC_STAGES`+1, where ACK is entered, `DevAck`=1 and `Ready`=1.
  - `IntReq` follows one cycle after `Ready`.
- `DevAck` falls one cycle after `req_s` falls.
- Minimum transfer period is 2·`SYNC_STAGES`+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- A shared package `inport_pkg` holds:
  - the state enum (IDLE, CAPTURE, ACK, ERR, 2-bit encoding);
  - status bit positions `ST_READY`=0, `ST_ERROR`=1, `ST_CNT_LSB`=8.
- Sub-module `sync_ff`: a parameterised-depth synchroniser with asynchronous active-low clear. It is reused for other off-chip inputs.
- The FSM, timer, counter and status logic stay in `inport_ctrl`.

## Test plan
- **Single transfer:** raise `DevReq` and hold it until `DevAck`, then drop it. Expect:
  - exactly one `Strobe` pulse, at cycle 3 after `DevReq` (with `SYNC_STAGES`=2);
  - `Ready`=1;
  - `StatusOut`=0x00000101;
  - `DevAck` low 3 cycles after `DevReq` falls.
- **Back-pressure:** do the first transfer without `CpuRead`, then raise `DevReq` again. Expect no `Strobe` and `DevAck` held at 0. Pulse `CpuRead` at cycle 20. Expect `Strobe` 1–2 cycles later and the count to reach 2.
- **Timeout:** with `TIMEOUT`=4, hold `DevReq` high indefinitely. Expect:
  - `DevAck` high for 4 cycles, then low;
  - `StatusOut`[1]=1;
  - `StatusClr` while the timeout is not active clears bit 1;
  - no second `Strobe` until `DevReq` goes low and high again.
- **Set/clear collision:** apply `CpuRead` in the exact cycle `Ready` is being set by CAPTURE. Expect `Ready`=1 afterwards. Then assert `IntEn`=1 and expect `IntReq`=1 one cycle later.
- **Counter wrap:** perform 256 transfers with `CNT_WIDTH`=8. Expect the count field to be 0x00 and `Ready`=1.
- **Asynchronous reset in ACK:** assert `Clear`=0 mid-cycle while in ACK. Expect `DevAck`, `Ready` and `StatusOut` to be 0 before the next `Clock` edge. After release, the FSM is in IDLE.
